// File: rtl/vga_dac_pkg.sv
// Shared constants, mode encoding and pixel-code payload for the VGA matrix-DAC scan controller.
package vga_dac_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned XY_W     = 10;
  localparam int unsigned CODE_W   = 4;
  localparam int unsigned ROW_BITS = 2;
  localparam int unsigned COL_BITS = 2;
  localparam int unsigned ROWS     = 4;
  localparam int unsigned COLS     = 4;
  localparam int unsigned BAR_PIX  = 80;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  typedef struct packed {
    logic [CODE_W-1:0] r;
    logic [CODE_W-1:0] g;
    logic [CODE_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_dac_scan_ctrl_if.sv
// Pixel request/return, sync and matrix-DAC select bundle between the scan controller and its neighbours.
interface vga_dac_scan_ctrl_if;
  import vga_dac_pkg::*;

  logic [XY_W-1:0]   pix_x;
  logic [XY_W-1:0]   pix_y;
  logic              frame_start;
  logic [CODE_W-1:0] pix_r;
  logic [CODE_W-1:0] pix_g;
  logic [CODE_W-1:0] pix_b;
  logic              hsync;
  logic              vsync;
  logic              blank;
  logic [ROWS-1:0]   r_row_full, g_row_full, b_row_full;
  logic [ROWS-1:0]   r_row_sel,  g_row_sel,  b_row_sel;
  logic [COLS-1:0]   r_col_th,   g_col_th,   b_col_th;

  modport master (
    output pix_x, pix_y, frame_start, hsync, vsync, blank,
    output r_row_full, g_row_full, b_row_full,
    output r_row_sel, g_row_sel, b_row_sel,
    output r_col_th, g_col_th, b_col_th,
    input  pix_r, pix_g, pix_b
  );

  modport slave (
    input  pix_x, pix_y, frame_start, hsync, vsync, blank,
    input  r_row_full, g_row_full, b_row_full,
    input  r_row_sel, g_row_sel, b_row_sel,
    input  r_col_th, g_col_th, b_col_th,
    output pix_r, pix_g, pix_b
  );
endinterface

// File: rtl/vga_dac_scan_ctrl_decode.sv
// Matrix DAC cell decode: upper code bits fill whole rows, lower bits fill a partial row.
module matrix_dac_decode
  import vga_dac_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [ROWS-1:0]   row_full,
  output logic [ROWS-1:0]   row_sel,
  output logic [COLS-1:0]   col_th
);

  logic [ROW_BITS-1:0] row_n;
  logic [COL_BITS-1:0] col_n;

  always_comb begin
    row_n    = code[CODE_W-1 -: ROW_BITS];
    col_n    = code[COL_BITS-1:0];
    row_full = '0;
    row_sel  = '0;
    col_th   = '0;
    for (int j = 0; j < ROWS; j++) begin
      row_full[j] = ROW_BITS'(j) < row_n;
      // No partial row when the column count is zero, so the lit-cell count equals the code.
      row_sel[j]  = (ROW_BITS'(j) == row_n) && (col_n != '0);
    end
    for (int i = 0; i < COLS; i++) begin
      col_th[i] = COL_BITS'(i) < col_n;
    end
  end

endmodule

// File: rtl/vga_dac_scan_ctrl.sv
// 640x480@60 VGA scan controller feeding R/G/B matrix DACs; one register stage aligns codes with syncs.
// Optional internal test patterns are built when VGA_DAC_TEST_PATTERN_EN is defined.
module vga_dac_scan_ctrl
  import vga_dac_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  vga_dac_scan_ctrl_if.master bus
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [XY_W-1:0] x_q, y_q, x_nxt, y_nxt;
  logic            fs_q;
  logic            in_active, hs_now, vs_now;
  logic            hsync_q, vsync_q, blank_q;
  rgb_t            ext_code, sel_code, code_q;

  // Raster counters.
  always_comb begin
    x_nxt = x_q + XY_W'(1);
    y_nxt = y_q;
    if (x_q == XY_W'(H_TOTAL - 1)) begin
      x_nxt = '0;
      y_nxt = (y_q == XY_W'(V_TOTAL - 1)) ? '0 : y_q + XY_W'(1);
    end
  end

  // frame_start is registered from the next counter value so it is high exactly while at (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      fs_q <= 1'b1;
    end else begin
      x_q  <= x_nxt;
      y_q  <= y_nxt;
      fs_q <= (x_nxt == '0) && (y_nxt == '0);
    end
  end

  always_comb begin
    in_active  = (x_q < XY_W'(H_ACTIVE)) && (y_q < XY_W'(V_ACTIVE));
    hs_now     = (x_q >= XY_W'(HS_START)) && (x_q < XY_W'(HS_END));
    vs_now     = (y_q >= XY_W'(VS_START)) && (y_q < XY_W'(VS_END));
    ext_code.r = bus.pix_r;
    ext_code.g = bus.pix_g;
    ext_code.b = bus.pix_b;
  end

`ifdef VGA_DAC_TEST_PATTERN_EN
  mode_e       mode_q, mode_eff;
  logic [2:0]  bar;
  logic [CODE_W-1:0] grad, chk;

  // Mode is captured on the frame_start cycle and used for that cycle too, so a frame is never split.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_EXT;
    end else if (fs_q) begin
      mode_q <= mode_e'(mode);
    end
  end

  always_comb begin
    mode_eff = fs_q ? mode_e'(mode) : mode_q;
    bar      = 3'(x_q / XY_W'(BAR_PIX));
    grad     = x_q[9:6];
    chk      = {CODE_W{x_q[5] ^ y_q[5]}};
    sel_code = ext_code;
    case (mode_eff)
      MODE_BARS: begin
        sel_code.r = {CODE_W{bar[2]}};
        sel_code.g = {CODE_W{bar[1]}};
        sel_code.b = {CODE_W{bar[0]}};
      end
      MODE_GRAD: begin
        sel_code.r = grad;
        sel_code.g = grad;
        sel_code.b = grad;
      end
      MODE_CHECK: begin
        sel_code.r = chk;
        sel_code.g = chk;
        sel_code.b = chk;
      end
      default: sel_code = ext_code;
    endcase
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign sel_code    = ext_code;
`endif

  // Output stage: syncs, blank and blank-forced codes share one register so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b1;
      code_q  <= '0;
    end else begin
      hsync_q <= !hs_now;
      vsync_q <= !vs_now;
      blank_q <= !in_active;
      code_q  <= in_active ? sel_code : '0;
    end
  end

  assign bus.pix_x       = x_q;
  assign bus.pix_y       = y_q;
  assign bus.frame_start = fs_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.blank       = blank_q;

  matrix_dac_decode u_dec_r (
    .code(code_q.r), .row_full(bus.r_row_full), .row_sel(bus.r_row_sel), .col_th(bus.r_col_th)
  );
  matrix_dac_decode u_dec_g (
    .code(code_q.g), .row_full(bus.g_row_full), .row_sel(bus.g_row_sel), .col_th(bus.g_col_th)
  );
  matrix_dac_decode u_dec_b (
    .code(code_q.b), .row_full(bus.b_row_full), .row_sel(bus.b_row_sel), .col_th(bus.b_col_th)
  );

endmodule

// File: tb/tb_vga_dac_scan_ctrl.sv
// Directed bench for vga_dac_scan_ctrl: full-width lines with a shortened vertical frame.
module tb_vga_dac_scan_ctrl;

  localparam int V_ACT = 34;
  localparam int V_FPL = 1;
  localparam int V_SY  = 2;
  localparam int V_BPL = 1;
  localparam int V_TOT = V_ACT + V_FPL + V_SY + V_BPL;
  localparam int FRAME = 800 * V_TOT;
  localparam int WAIT_MAX = 40000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  int         n_checks = 0;
  int         n_fail   = 0;

  logic mon_go = 1'b0, mon_done = 1'b0;
  int   n_hpulse = 0, bad_w = 0, n_vlow = 0, fs_idx = -1, n_fs = 0;

  vga_dac_scan_ctrl_if bus ();

  vga_dac_scan_ctrl #(
    .V_ACTIVE(V_ACT), .V_FP(V_FPL), .V_SYNC(V_SY), .V_BP(V_BPL)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand-computed {row_full,row_sel,col_th} for each code.
  function automatic logic [11:0] exp_dec(input int c);
    case (c)
      0:  return 12'b0000_0000_0000;
      1:  return 12'b0000_0001_0001;
      2:  return 12'b0000_0001_0011;
      3:  return 12'b0000_0001_0111;
      4:  return 12'b0001_0000_0000;
      5:  return 12'b0001_0010_0001;
      6:  return 12'b0001_0010_0011;
      7:  return 12'b0001_0010_0111;
      8:  return 12'b0011_0000_0000;
      9:  return 12'b0011_0100_0001;
      10: return 12'b0011_0100_0011;
      11: return 12'b0011_0100_0111;
      12: return 12'b0111_0000_0000;
      13: return 12'b0111_1000_0001;
      14: return 12'b0111_1000_0011;
      default: return 12'b0111_1000_0111;
    endcase
  endfunction

  function automatic int cells_on(input logic [11:0] s);
    int n = 0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        if (s[8 + j] || (s[4 + j] && s[i])) n++;
    return n;
  endfunction

  function automatic logic [11:0] r_sel();
    return {bus.r_row_full, bus.r_row_sel, bus.r_col_th};
  endfunction
  function automatic logic [11:0] g_sel();
    return {bus.g_row_full, bus.g_row_sel, bus.g_col_th};
  endfunction
  function automatic logic [11:0] b_sel();
    return {bus.b_row_full, bus.b_row_sel, bus.b_col_th};
  endfunction

  task automatic wait_xy(input int x, input int y);
    for (int n = 0; n < WAIT_MAX; n++) begin
      @(negedge clk);
      if (bus.pix_x == 10'(x) && bus.pix_y == 10'(y)) return;
    end
    check("wait_xy_timeout", 64'(x * 1000 + y), 64'hFFFF_FFFF);
  endtask

  // Frame-long sync/frame_start monitor, started at the release of reset.
  initial begin
    int cur_w = 0;
    logic prev_h = 1'b1;
    wait (mon_go);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (prev_h && !bus.hsync) n_hpulse++;
      if (!bus.hsync) cur_w++;
      if (!prev_h && bus.hsync) begin
        if (cur_w != 96) bad_w++;
        cur_w = 0;
      end
      if (!bus.vsync) n_vlow++;
      if (bus.frame_start) begin
        n_fs++;
        if (fs_idx < 0) fs_idx = i;
      end
      prev_h = bus.hsync;
    end
    mon_done = 1'b1;
  end

  initial begin
    rst = 1'b1;
    mode = 2'd0;
    bus.pix_r = 4'h0; bus.pix_g = 4'h0; bus.pix_b = 4'h0;
    repeat (3) @(negedge clk);

    check("rst_x", 64'(bus.pix_x), 64'd0);
    check("rst_y", 64'(bus.pix_y), 64'd0);
    check("rst_syncs", 64'({bus.hsync, bus.vsync, bus.blank}), 64'b111);
    check("rst_sel", 64'({r_sel(), g_sel(), b_sel()}), 64'd0);
    check("rst_fs", 64'(bus.frame_start), 64'd1);

    bus.pix_r = 4'hB; bus.pix_g = 4'h5; bus.pix_b = 4'hF;
    rst = 1'b0;
    mon_go = 1'b1;

    // Line 0: first/last visible pixel alignment, one cycle behind pix_x.
    wait_xy(1, 0);
    check("x0_blank", 64'(bus.blank), 64'd0);
    check("x0_fs", 64'(bus.frame_start), 64'd0);
    check("x0_r", 64'(r_sel()), 64'(12'b0011_0100_0111));
    check("x0_g", 64'(g_sel()), 64'(12'b0001_0010_0001));
    check("x0_b", 64'(b_sel()), 64'(12'b0111_1000_0111));
    wait_xy(640, 0);
    check("x639_blank", 64'(bus.blank), 64'd0);
    check("x639_r", 64'(r_sel()), 64'(12'b0011_0100_0111));
    wait_xy(641, 0);
    check("x640_blank", 64'(bus.blank), 64'd1);
    check("x640_sel", 64'({r_sel(), g_sel(), b_sel()}), 64'd0);
    wait_xy(656, 0);
    check("hs_655", 64'(bus.hsync), 64'd1);
    wait_xy(657, 0);
    check("hs_656", 64'(bus.hsync), 64'd0);
    wait_xy(752, 0);
    check("hs_751", 64'(bus.hsync), 64'd0);
    wait_xy(753, 0);
    check("hs_752", 64'(bus.hsync), 64'd1);

    // Decode sweep across all codes on line 1.
    wait_xy(99, 1);
    for (int c = 0; c < 16; c++) begin
      bus.pix_r = 4'(c); bus.pix_g = 4'(15 - c); bus.pix_b = 4'(c);
      @(negedge clk);
      check($sformatf("dec_r%0d", c), 64'(r_sel()), 64'(exp_dec(c)));
      check($sformatf("dec_g%0d", 15 - c), 64'(g_sel()), 64'(exp_dec(15 - c)));
      check($sformatf("cells_b%0d", c), 64'(cells_on(b_sel())), 64'(c));
    end
    bus.pix_r = 4'hB; bus.pix_g = 4'h5; bus.pix_b = 4'hF;

    // Mid-frame mode change must wait for the next frame.
    wait_xy(0, 20);
    mode = 2'd1;
    wait_xy(101, 20);
    check("midframe_ext_r", 64'(r_sel()), 64'(12'b0011_0100_0111));
    wait_xy(0, 0);
    wait_xy(81, 0);
`ifdef VGA_DAC_TEST_PATTERN_EN
    check("bar1_rg", 64'({r_sel(), g_sel()}), 64'd0);
    check("bar1_b", 64'(b_sel()), 64'(12'b0111_1000_0111));
    wait_xy(160, 0);
    check("bar1_end_b", 64'(b_sel()), 64'(12'b0111_1000_0111));
    wait_xy(161, 0);
    check("bar2_rb", 64'({r_sel(), b_sel()}), 64'd0);
    check("bar2_g", 64'(g_sel()), 64'(12'b0111_1000_0111));
`else
    check("noen_ext_r", 64'(r_sel()), 64'(12'b0011_0100_0111));
    check("noen_ext_b", 64'(b_sel()), 64'(12'b0111_1000_0111));
`endif

    for (int n = 0; n < WAIT_MAX && !mon_done; n++) @(negedge clk);
    check("mon_done", 64'(mon_done), 64'd1);
    check("hsync_pulses", 64'(n_hpulse), 64'(V_TOT));
    check("hsync_width_bad", 64'(bad_w), 64'd0);
    check("vsync_low", 64'(n_vlow), 64'd1600);
    check("fs_period", 64'(fs_idx + 1), 64'(FRAME));
    check("fs_count", 64'(n_fs), 64'd1);

    // Mid-frame reset restarts the scan at (0,0).
    mode = 2'd3;
    wait_xy(300, 10);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_xy", 64'({bus.pix_x, bus.pix_y}), 64'd0);
    check("mrst_hs_blank", 64'({bus.hsync, bus.blank}), 64'b11);
    check("mrst_fs", 64'(bus.frame_start), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_x1", 64'(bus.pix_x), 64'd1);
    check("mrst_fs_low", 64'(bus.frame_start), 64'd0);
    check("mrst_blank_low", 64'(bus.blank), 64'd0);

`ifdef VGA_DAC_TEST_PATTERN_EN
    check("chk_0_0", 64'({r_sel(), g_sel(), b_sel()}), 64'd0);
    wait_xy(32, 0);
    check("chk_31_0", 64'({r_sel(), g_sel(), b_sel()}), 64'd0);
    wait_xy(33, 0);
    check("chk_32_0", 64'({r_sel(), g_sel(), b_sel()}), 64'({3{12'b0111_1000_0111}}));
    wait_xy(33, 32);
    check("chk_32_32", 64'({r_sel(), g_sel(), b_sel()}), 64'd0);
`else
    check("noen_rst_r", 64'(r_sel()), 64'(12'b0011_0100_0111));
    wait_xy(33, 32);
    check("noen_32_32_g", 64'(g_sel()), 64'(12'b0001_0010_0001));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
